// File: rtl/instr_reg_sched.sv
// Scheduler for a 32-entry circular instruction register. Two requesters share
// one write port through a round-robin arbiter, and a single consumer pops in order.

package instr_reg_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0]        address_t;
    typedef logic signed [DATA_W-1:0] operand_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5,
        OP_DIV = 3'd6,
        OP_MOD = 3'd7
    } opcode_t;
endpackage

module instr_reg_sched
    import instr_reg_pkg::*;
#(
    parameter int DEPTH = 2**$bits(address_t)
) (
    input  logic       clk,
    input  logic       reset_n,

    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  opcode_t    req0_opcode,
    input  operand_t   req0_operand_a,
    input  operand_t   req0_operand_b,
    input  opcode_t    req1_opcode,
    input  operand_t   req1_operand_a,
    input  operand_t   req1_operand_b,

    input  logic       flush,

    output logic       load_en,
    output opcode_t    opcode,
    output operand_t   operand_a,
    output operand_t   operand_b,
    output address_t   write_pointer,

    output address_t   read_pointer,
    output logic       rd_valid,
    input  logic       rd_ready,

    output logic [5:0] count,
    output logic       full,
    output logic       empty,
    output logic       err_div0
);

    address_t   wr_ptr;
    address_t   rd_ptr;
    logic [5:0] count_q;
    logic       err_q;
    logic       last_grant;

    logic       grant_idx;
    logic       grant_any;
    logic       push;
    logic       pop;
    logic       div0_hit;

    function automatic logic is_div_zero(input opcode_t op, input operand_t b);
        return ((op == OP_DIV) || (op == OP_MOD)) && (b == '0);
    endfunction

    assign full  = (count_q == 6'(DEPTH));
    assign empty = (count_q == 6'd0);

    // Contention goes to the requester that was not served last.
    always_comb begin
        grant_idx = 1'b0;
        grant_any = 1'b0;
        case (req_valid)
            2'b01: begin grant_idx = 1'b0;        grant_any = 1'b1; end
            2'b10: begin grant_idx = 1'b1;        grant_any = 1'b1; end
            2'b11: begin grant_idx = ~last_grant; grant_any = 1'b1; end
            default: ;
        endcase
    end

    // A full queue refuses pushes even when a pop lands in the same cycle.
    always_comb begin
        req_ready = 2'b00;
        if (reset_n && grant_any && !full && !flush)
            req_ready[grant_idx] = 1'b1;
    end

    assign push = |(req_valid & req_ready);
    assign pop  = rd_valid && rd_ready && !flush;

    assign load_en       = push;
    assign opcode        = grant_idx ? req1_opcode    : req0_opcode;
    assign operand_a     = grant_idx ? req1_operand_a : req0_operand_a;
    assign operand_b     = grant_idx ? req1_operand_b : req0_operand_b;
    assign write_pointer = wr_ptr;
    assign div0_hit      = push && is_div_zero(opcode, operand_b);

    assign read_pointer = rd_ptr;
    assign rd_valid     = !empty;
    assign count        = count_q;
    assign err_div0     = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            last_grant <= 1'b1;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + address_t'(1);
                last_grant <= grant_idx;
            end
            if (pop)
                rd_ptr <= rd_ptr + address_t'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 6'd1;
                2'b01:   count_q <= count_q - 6'd1;
                default: count_q <= count_q;
            endcase
            if (div0_hit)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_reg_sched.sv
// Bench for instr_reg_sched: directed scenarios plus a randomized run against a
// queue-based reference model of the scheduler.

module tb_instr_reg_sched;
    import instr_reg_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    opcode_t    req0_opcode, req1_opcode;
    operand_t   req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
    logic       flush;
    logic       load_en;
    opcode_t    opcode;
    operand_t   operand_a, operand_b;
    address_t   write_pointer, read_pointer;
    logic       rd_valid, rd_ready;
    logic [5:0] count;
    logic       full, empty, err_div0;

    int n_checks = 0;
    int n_pass   = 0;

    instr_reg_sched #(.DEPTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_opcode(req0_opcode), .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
        .req1_opcode(req1_opcode), .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
        .flush(flush), .load_en(load_en), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .write_pointer(write_pointer),
        .read_pointer(read_pointer), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .count(count), .full(full), .empty(empty), .err_div0(err_div0)
    );

    always #5 clk = ~clk;

    // External instruction register written through the DUT's write port.
    opcode_t  mem_op [32];
    operand_t mem_a  [32];
    operand_t mem_b  [32];
    always @(posedge clk) begin
        if (load_en) begin
            mem_op[write_pointer] <= opcode;
            mem_a[write_pointer]  <= operand_a;
            mem_b[write_pointer]  <= operand_b;
        end
    end

    typedef struct packed {
        opcode_t  op;
        operand_t a;
        operand_t b;
    } entry_t;

    entry_t mq[$];
    int     m_wr, m_rd, m_last;
    bit     m_err;

    function automatic logic [1:0] model_ready(input logic [1:0] v, input logic fl);
        if (fl || mq.size() >= 32 || v == 2'b00) return 2'b00;
        if (v == 2'b01) return 2'b01;
        if (v == 2'b10) return 2'b10;
        return (m_last == 1) ? 2'b01 : 2'b10;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wr = 0; m_rd = 0; m_last = 1; m_err = 0;
    endtask

    task automatic idle();
        req_valid = 2'b00; rd_ready = 1'b0; flush = 1'b0;
        req0_opcode = OP_ADD; req0_operand_a = '0; req0_operand_b = 16'sd1;
        req1_opcode = OP_ADD; req1_operand_a = '0; req1_operand_b = 16'sd1;
    endtask

    task automatic rand_fields(input bit allow_zero_b);
        req0_opcode    = opcode_t'($urandom_range(0, 7));
        req1_opcode    = opcode_t'($urandom_range(0, 7));
        req0_operand_a = operand_t'(16'($urandom));
        req1_operand_a = operand_t'(16'($urandom));
        req0_operand_b = operand_t'(16'($urandom_range(allow_zero_b ? 0 : 1, 3)));
        req1_operand_b = operand_t'(16'($urandom_range(allow_zero_b ? 0 : 1, 3)));
    endtask

    // Advances one clock with the current inputs and applies the model's view of it.
    task automatic tick();
        logic [1:0] g;
        bit         do_pop;
        entry_t     e;
        #1;
        g      = model_ready(req_valid, flush);
        do_pop = (mq.size() > 0) && rd_ready && !flush;
        @(posedge clk);
        if (flush) begin
            mq.delete(); m_wr = 0; m_rd = 0; m_err = 0;
        end else begin
            if (do_pop) begin
                void'(mq.pop_front());
                m_rd = (m_rd + 1) % 32;
            end
            if (g != 2'b00) begin
                e.op = g[1] ? req1_opcode    : req0_opcode;
                e.a  = g[1] ? req1_operand_a : req0_operand_a;
                e.b  = g[1] ? req1_operand_b : req0_operand_b;
                mq.push_back(e);
                m_wr   = (m_wr + 1) % 32;
                m_last = g[1] ? 1 : 0;
                if ((e.op == OP_DIV || e.op == OP_MOD) && e.b == 0) m_err = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_flush();
        idle(); flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 2'b11; rd_ready = 1'b1;
        #2;
        n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", req_ready); else n_pass++;
        n_checks++; if (load_en !== 1'b0) $display("FAIL reset_load_en got=%b exp=0", load_en); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
        n_checks++; if (count !== 6'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
        @(negedge clk);
        idle(); reset_n = 1'b1; model_reset();
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            rand_fields(1'b0);
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            n_checks++; if (req_ready !== exp) $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, exp); else n_pass++;
            n_checks++; if (write_pointer !== address_t'(i)) $display("FAIL rr_wptr%0d got=%0d exp=%0d", i, write_pointer, i); else n_pass++;
            tick();
        end
        idle();
        n_checks++; if (count !== 6'd4) $display("FAIL rr_count got=%0d exp=4", count); else n_pass++;
        do_flush();
        n_checks++; if (count !== 6'd0) $display("FAIL rr_flush_count got=%0d exp=0", count); else n_pass++;
    endtask

    task automatic test_add_pop();
        int sum;
        idle();
        req_valid = 2'b01; req0_opcode = OP_ADD; req0_operand_a = 16'sd5; req0_operand_b = 16'sd3;
        tick();
        idle();
        sum = int'(mem_a[0]) + int'(mem_b[0]);
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL add_rd_valid got=%b exp=1", rd_valid); else n_pass++;
        n_checks++; if (read_pointer !== address_t'(0)) $display("FAIL add_rptr got=%0d exp=0", read_pointer); else n_pass++;
        n_checks++; if (mem_op[0] !== OP_ADD) $display("FAIL add_opcode got=%0d exp=%0d", mem_op[0], OP_ADD); else n_pass++;
        n_checks++; if (sum != 8) $display("FAIL add_result got=%0d exp=8", sum); else n_pass++;
        rd_ready = 1'b1;
        tick();
        idle();
        n_checks++; if (count !== 6'd0) $display("FAIL add_pop_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL add_pop_empty got=%b exp=1", empty); else n_pass++;
    endtask

    task automatic test_full_wrap();
        do_flush();
        for (int i = 0; i < 32; i++) begin
            rand_fields(1'b0);
            req_valid = 2'($urandom_range(1, 3));
            #1;
            n_checks++; if (load_en !== 1'b1 || write_pointer !== address_t'(i))
                $display("FAIL fill%0d load_en=%b wptr=%0d exp load_en=1 wptr=%0d", i, load_en, write_pointer, i); else n_pass++;
            tick();
        end
        req_valid = 2'b11;
        #1;
        n_checks++; if (full !== 1'b1) $display("FAIL full_flag got=%b exp=1", full); else n_pass++;
        n_checks++; if (count !== 6'd32) $display("FAIL full_count got=%0d exp=32", count); else n_pass++;
        n_checks++; if (req_ready !== 2'b00) $display("FAIL full_ready got=%b exp=00", req_ready); else n_pass++;
        req_valid = 2'b01; rd_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 2'b00) $display("FAIL full_pop_ready got=%b exp=00", req_ready); else n_pass++;
        tick();
        n_checks++; if (count !== 6'd31) $display("FAIL full_pop_count got=%0d exp=31", count); else n_pass++;
        rd_ready = 1'b0; req_valid = 2'b10;
        #1;
        n_checks++; if (req_ready !== 2'b10) $display("FAIL wrap_ready got=%b exp=10", req_ready); else n_pass++;
        n_checks++; if (write_pointer !== address_t'(0)) $display("FAIL wrap_wptr got=%0d exp=0", write_pointer); else n_pass++;
        tick();
        idle();
        n_checks++; if (count !== 6'd32) $display("FAIL wrap_count got=%0d exp=32", count); else n_pass++;
    endtask

    task automatic test_div0();
        do_flush();
        req_valid = 2'b10; req1_opcode = OP_DIV; req1_operand_a = 16'sd7; req1_operand_b = 16'sd0;
        tick();
        n_checks++; if (err_div0 !== 1'b1) $display("FAIL div0_set got=%b exp=1", err_div0); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            rand_fields(1'b0);
            req_valid = 2'b11;
            tick();
            n_checks++; if (err_div0 !== 1'b1) $display("FAIL div0_sticky%0d got=%b exp=1", i, err_div0); else n_pass++;
        end
        do_flush();
        n_checks++; if (err_div0 !== 1'b0) $display("FAIL div0_flush got=%b exp=0", err_div0); else n_pass++;
        n_checks++; if (count !== 6'd0) $display("FAIL div0_flush_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL div0_flush_rd_valid got=%b exp=0", rd_valid); else n_pass++;
        req_valid = 2'b01; req0_opcode = OP_DIV; req0_operand_a = 16'sd9; req0_operand_b = 16'sd3;
        tick();
        n_checks++; if (err_div0 !== 1'b0) $display("FAIL div_nonzero got=%b exp=0", err_div0); else n_pass++;
        req0_opcode = OP_MOD; req0_operand_b = 16'sd0;
        tick();
        n_checks++; if (err_div0 !== 1'b1) $display("FAIL mod0_set got=%b exp=1", err_div0); else n_pass++;
        do_flush();
    endtask

    task automatic test_async_reset();
        do_flush();
        req_valid = 2'b01;
        repeat (5) begin rand_fields(1'b0); tick(); end
        idle();
        n_checks++; if (count !== 6'd5) $display("FAIL ares_pre_count got=%0d exp=5", count); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (count !== 6'd0) $display("FAIL ares_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL ares_empty got=%b exp=1", empty); else n_pass++;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        req_valid = 2'b11;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL ares_first_grant got=%b exp=01", req_ready); else n_pass++;
        tick();
        #1;
        n_checks++; if (req_ready !== 2'b10) $display("FAIL ares_second_grant got=%b exp=10", req_ready); else n_pass++;
        tick();
        idle();
    endtask

    task automatic test_empty_pop();
        do_flush();
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (read_pointer !== address_t'(0) || count !== 6'd0)
                $display("FAIL empty_pop%0d rptr=%0d count=%0d exp rptr=0 count=0", i, read_pointer, count); else n_pass++;
        end
        idle();
    endtask

    task automatic test_random();
        logic [1:0] er;
        entry_t     h;
        bit         bad;
        do_flush();
        for (int c = 0; c < 800; c++) begin
            rand_fields(1'b1);
            req_valid = 2'($urandom_range(0, 3));
            rd_ready  = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 119) == 0);
            #1;
            er = model_ready(req_valid, flush);
            n_checks++; if (req_ready !== er || load_en !== (er != 2'b00))
                $display("FAIL rnd%0d ready=%b load_en=%b exp ready=%b", c, req_ready, load_en, er); else n_pass++;
            if (er != 2'b00) begin
                n_checks++; if (opcode !== (er[1] ? req1_opcode : req0_opcode) ||
                                operand_b !== (er[1] ? req1_operand_b : req0_operand_b))
                    $display("FAIL rnd%0d mux op=%0d b=%0d", c, opcode, operand_b); else n_pass++;
            end
            bad = (write_pointer !== address_t'(m_wr)) || (read_pointer !== address_t'(m_rd)) ||
                  (count !== 6'(mq.size())) || (full !== (mq.size() == 32)) ||
                  (empty !== (mq.size() == 0)) || (rd_valid !== (mq.size() != 0)) || (err_div0 !== m_err);
            n_checks++; if (bad)
                $display("FAIL rnd%0d state wptr=%0d rptr=%0d cnt=%0d full=%b empty=%b err=%b exp wptr=%0d rptr=%0d cnt=%0d err=%b",
                         c, write_pointer, read_pointer, count, full, empty, err_div0, m_wr, m_rd, mq.size(), m_err); else n_pass++;
            if (mq.size() > 0 && rd_ready && !flush) begin
                h = mq[0];
                n_checks++; if (mem_op[m_rd] !== h.op || mem_a[m_rd] !== h.a || mem_b[m_rd] !== h.b)
                    $display("FAIL rnd%0d word op=%0d a=%0d b=%0d exp op=%0d a=%0d b=%0d",
                             c, mem_op[m_rd], mem_a[m_rd], mem_b[m_rd], h.op, h.a, h.b); else n_pass++;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_round_robin();
        test_add_pop();
        test_full_wrap();
        test_div0();
        test_async_reset();
        test_empty_pop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_reg_sched.md
INSTR_REG_SCHED -- requirements
Module: instr_reg_sched

Interface
REQ-001 Parameter: DEPTH, 32, number of instruction register entries; SHALL equal 2**$bits(address_t).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  2  per-requester instruction-valid flags (bit 0 = requester 0, bit 1 = requester 1).
REQ-005 Port: req_ready  output  2  per-requester accept; a transfer occurs when req_valid[i] && req_ready[i] at posedge clk.
REQ-006 Port: req0_opcode, req1_opcode  input  opcode_t  opcode from each requester.
REQ-007 Port: req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b  input  operand_t  operands from each requester.
REQ-008 Port: flush  input  1  synchronous clear of queue state.
REQ-009 Port: load_en  output  1  write strobe to the instruction register.
REQ-010 Port: opcode, operand_a, operand_b  output  opcode_t/operand_t  granted requester's fields to the instruction register.
REQ-011 Port: write_pointer  output  address_t  entry written when load_en=1.
REQ-012 Port: read_pointer  output  address_t  oldest unread entry.
REQ-013 Port: rd_valid  output  1  read_pointer addresses a valid entry.
REQ-014 Port: rd_ready  input  1  consumer pops the entry when rd_valid && rd_ready.
REQ-015 Port: count  output  6  entries held, 0..32.
REQ-016 Port: full, empty  output  1 each  count==32, count==0.
REQ-017 Port: err_div0  output  1  sticky flag: a DIV or MOD with operand_b==0 was accepted.

Function
REQ-018 Block SHALL implement a 32-entry circular queue over the instruction register: wr_ptr, rd_ptr, count registers.
REQ-019 Arbitration SHALL be round-robin over the two requesters using a last_grant register; a single requester valid is granted; if both are valid, the one not equal to last_grant is granted.
REQ-020 At most one req_ready bit SHALL be 1 per cycle; req_ready SHALL be 0 for both when full=1 or flush=1.
REQ-021 req_ready[i] SHALL be combinational from req_valid, last_grant, full, flush; it SHALL be 1 only for the granted, valid requester.
REQ-022 load_en SHALL equal |(req_valid & req_ready); opcode/operands SHALL be muxed from the granted requester; write_pointer SHALL equal wr_ptr; the write occurs at the same edge as the handshake (zero latency).
REQ-023 On an accept, wr_ptr SHALL increment modulo 32 (31 -> 0) and last_grant SHALL take the granted index; otherwise both hold.
REQ-024 read_pointer SHALL equal rd_ptr; rd_valid SHALL equal !empty; on pop, rd_ptr SHALL increment modulo 32.
REQ-025 rd_ready while empty SHALL have no effect.
REQ-026 count SHALL update as: push only +1, pop only -1, push and pop in the same cycle unchanged.
REQ-027 When full, a pop in the same cycle SHALL NOT enable a push (no same-cycle fall-through); the push is accepted on the next cycle.
REQ-028 flush=1 SHALL, at the next edge, set wr_ptr=rd_ptr=0, count=0, err_div0=0; flush SHALL override push and pop in that cycle; last_grant holds.
REQ-029 err_div0 SHALL set on an accept whose opcode is DIV or MOD with operand_b==0, and SHALL stay set until flush or reset.

Reset
REQ-030 reset_n=0 SHALL asynchronously clear wr_ptr, rd_ptr, count, err_div0 to 0 and set last_grant=1 (requester 0 wins the first contention).
REQ-031 During reset, req_ready=0, load_en=0, rd_valid=0, empty=1, full=0; a reset mid-operation discards all queued entries.

Verification
REQ-032 Reset, then req_valid=2'b11 held for 4 cycles -> grants 0,1,0,1; write_pointer 0,1,2,3; count=4.
REQ-033 Requester 0 pushes ADD a=5 b=3 at entry 0; rd_ready=1 -> rd_valid=1, read_pointer=0, instruction word result 8; count returns to 0, empty=1.
REQ-034 32 pushes with no pop -> full=1, count=32, req_ready=0; push+pop in the same cycle -> pop only, count=31; next push goes to write_pointer=0 (wrap).
REQ-035 Accept DIV a=7 b=0 -> err_div0=1 and stays 1 across further pushes; flush -> err_div0=0, count=0, rd_valid=0.
REQ-036 Queue at count=5, assert reset_n=0 between clock edges -> count=0, empty=1 immediately, without waiting for a clock edge; after release, first contention is granted to requester 0.
REQ-037 Empty queue, rd_ready=1 for 3 cycles -> rd_ptr stays 0, count stays 0.
